// File: rtl/div_stall_unit.sv
// Multi-cycle restoring divider for the execute stage (DIV/DIVU).
// Raises div_stall until the quotient/remainder are ready, holds them while the pipeline is held, and drops the operation on flush.
module div_stall_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_validE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hold,
    input  logic             flush,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   rem_sub_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg2c(x) : x;
    endfunction

    // One restoring step on the shifted {rem, quo} pair; 33-bit compare covers divisors above 2^31.
    always_comb begin
        rem_sh_s   = {rem_q, quo_q[WIDTH-1]};
        rem_sub_s  = rem_sh_s - {1'b0, dvsr_q};
        ge_s       = (rem_sh_s >= {1'b0, dvsr_q});
        rem_step_s = ge_s ? rem_sub_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
        quo_step_s = {quo_q[WIDTH-2:0], ge_s};
    end

    // Next-state and datapath update; flush overrides everything and leaves hi/lo untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        araw_d  = araw_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_validE) begin
                        quo_d   = mag(a, signedE);
                        dvsr_d  = mag(b, signedE);
                        araw_d  = a;
                        qneg_d  = signedE & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = signedE & a[WIDTH-1];
                        bzero_d = (b == {WIDTH{1'b0}});
                        rem_d   = {WIDTH{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    rem_d = rem_step_s;
                    quo_d = quo_step_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_DONE;
                        if (bzero_q) begin
                            lo_d = {WIDTH{1'b1}};
                            hi_d = araw_q;
                        end else begin
                            lo_d = qneg_q ? neg2c(quo_step_s) : quo_step_s;
                            hi_d = rneg_q ? neg2c(rem_step_s) : rem_step_s;
                        end
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_DONE: begin
                    // Same instruction still parked in E: keep the result, never restart.
                    if (div_validE && hold) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            dvsr_q  <= {WIDTH{1'b0}};
            araw_q  <= {WIDTH{1'b0}};
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            araw_q  <= araw_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign div_stall    = div_validE & ~flush & (state_q != S_DONE);
    assign result_valid = (state_q == S_DONE) & ~flush;
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit: stall length, signed/unsigned results, hold, flush, back-to-back and reset abort.
module tb_div_stall_unit;

    logic        clk;
    logic        rst;
    logic        div_validE;
    logic        signedE;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;
    logic        flush;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;
    int stalls;

    div_stall_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_validE   (div_validE),
        .signedE      (signedE),
        .a            (a),
        .b            (b),
        .hold         (hold),
        .flush        (flush),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a divide in E just after the next rising edge (that cycle is C0).
    task automatic start_div(input logic [31:0] aa, input logic [31:0] bb, input logic s);
        @(posedge clk);
        #1;
        div_validE = 1'b1;
        signedE    = s;
        a          = aa;
        b          = bb;
    endtask

    // Count stall cycles until result_valid; returns at the falling edge of the DONE cycle.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (result_valid) break;
            if (div_stall) n++;
        end
        check("done_seen", {31'd0, result_valid}, 32'd1);
        check("done_stall", {31'd0, div_stall}, 32'd0);
    endtask

    // Let the instruction leave E and confirm the result is withdrawn.
    task automatic retire;
        @(posedge clk);
        #1;
        div_validE = 1'b0;
        @(negedge clk);
        check("retired_rv", {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        div_validE = 1'b0;
        signedE = 1'b0;
        a = 32'd0;
        b = 32'd0;
        hold = 1'b0;
        flush = 1'b0;

        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_rv", {31'd0, result_valid}, 32'd0);
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // DIVU 100 / 7
        start_div(32'd100, 32'd7, 1'b0);
        wait_done(stalls);
        check("divu_stalls", 32'(stalls), 32'd33);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        retire();

        // DIV -7 / 2
        start_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(stalls);
        check("divs_lo", lo, 32'hFFFF_FFFD);
        check("divs_hi", hi, 32'hFFFF_FFFF);
        retire();

        // DIV overflow 0x80000000 / -1
        start_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(stalls);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);
        retire();

        // DIVU by zero
        start_div(32'h0000_1234, 32'd0, 1'b0);
        wait_done(stalls);
        check("dz_stalls", 32'(stalls), 32'd33);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_hi", hi, 32'h0000_1234);
        retire();

        // DIV 7 / -2 with a signed result mix (q=-3, r=1)
        start_div(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done(stalls);
        check("divs2_lo", lo, 32'hFFFF_FFFD);
        check("divs2_hi", hi, 32'd1);
        retire();

        // Hold from C33 for five cycles
        start_div(32'd50, 32'd5, 1'b0);
        wait_done(stalls);
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_rv", {31'd0, result_valid}, 32'd1);
            check("hold_stall", {31'd0, div_stall}, 32'd0);
            check("hold_lo", lo, 32'd10);
        end
        @(posedge clk);
        #1 hold = 1'b0;
        @(negedge clk);
        check("hold_fall_rv", {31'd0, result_valid}, 32'd1);
        check("hold_fall_hi", hi, 32'd0);
        retire();

        // Flush at C10, idle at C11, new divide at C12
        start_div(32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'd0, div_stall}, 32'd0);
        check("flush_rv", {31'd0, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        div_validE = 1'b0;
        @(negedge clk);
        check("flush_c11_rv", {31'd0, result_valid}, 32'd0);
        start_div(32'd200, 32'd8, 1'b0);
        wait_done(stalls);
        check("post_flush_stalls", 32'(stalls), 32'd33);
        check("post_flush_lo", lo, 32'd25);
        check("post_flush_hi", hi, 32'd0);
        retire();

        // Back-to-back: 200/10 then 9/4
        start_div(32'd200, 32'd10, 1'b0);
        wait_done(stalls);
        check("b2b1_stalls", 32'(stalls), 32'd33);
        check("b2b1_lo", lo, 32'd20);
        start_div(32'd9, 32'd4, 1'b0);
        wait_done(stalls);
        check("b2b2_stalls", 32'(stalls), 32'd33);
        check("b2b2_lo", lo, 32'd2);
        check("b2b2_hi", hi, 32'd1);
        retire();

        // Reset at C20 of a third divide
        start_div(32'd1000, 32'd3, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_stall", {31'd0, div_stall}, 32'd1);
        rst = 1'b0;
        div_validE = 1'b0;
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_rv", {31'd0, result_valid}, 32'd0);
        check("abort_stall", {31'd0, div_stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_stall_unit.md
# div_stall_unit

Multi-cycle 32-bit integer divider in the execute stage, and the source of the divider stall request that the pipeline hazard/stall controller consumes. It accepts a DIV/DIVU when the instruction is in E and holds the pipeline with `div_stall` until quotient and remainder are ready. It keeps the result stable while other stall sources hold the pipeline, and abandons the operation when the controller flushes E.

## Interface
- `WIDTH`, 32, operand and result width; iteration count equals `WIDTH`.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `div_validE`  in  1  a DIV/DIVU instruction occupies E this cycle.
- `signedE`  in  1  1 = DIV (two's-complement), 0 = DIVU.
- `a`  in  WIDTH  dividend (rs value, post-forwarding).
- `b`  in  WIDTH  divisor (rt value, post-forwarding).
- `hold`  in  1  OR of all non-divider stall sources (i_stall | d_stall | mult_stallE). It must not include `div_stall`, to avoid a combinational loop.
- `flush`  in  1  E-stage flush: exception, or branch mispredict not blocked by a stall.
- `div_stall`  out  1  stall request to the hazard unit.
- `result_valid`  out  1  `hi`/`lo` hold the result for the instruction in E.
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, with `div_validE & ~flush`:
  - latch |a|, |b| (magnitudes when `signedE`, raw otherwise), quotient sign = a[31]^b[31], remainder sign = a[31];
  - clear the iteration counter and partial remainder;
  - go to BUSY.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem ≥ |b|, then rem -= |b| and quo[0] = 1.
  - The 5-bit counter increments. After step WIDTH-1 (counter 31), go to DONE and register sign-corrected `hi`/`lo`.
- DONE:
  - `result_valid`=1, `div_stall`=0.
  - Stay in DONE while `div_validE & hold`: the same instruction is still in E. Never restart it.
  - Go to IDLE when `~hold | ~div_validE`: the instruction has advanced.
- Sign correction (signed only): negate the quotient if its sign bit is set; negate the remainder if a[31]=1.
- Divide by zero (b=0): `lo`=0xFFFFFFFF, `hi`=a. No sign correction. Same latency.
- Overflow 0x80000000 / -1 (signed): `lo`=0x80000000, `hi`=0. This is the natural result and needs no special case.
- `div_stall` is combinational: `div_validE & ~flush & (state != DONE)`. It is therefore asserted in the very cycle the divide enters E.
- `flush` in any state: next state IDLE, `result_valid` cleared, and `div_stall` deasserted in the same cycle. Operands arriving in a flush cycle are ignored.
- `hi`/`lo` change only on the BUSY→DONE transition. The consumer samples them when `result_valid`=1.

## Timing
- Reset (async, `rst`=0): state IDLE, counter 0, `hi`=0, `lo`=0, `result_valid`=0, internal regs 0. `div_stall` follows its equation and reads 0 while `div_validE`=0.
- Latency, with the divide entering E in cycle C0:
  - C0: IDLE, `div_stall`=1.
  - C1–C32: BUSY, 32 iterations, `div_stall`=1.
  - C33: DONE, `div_stall`=0, `result_valid`=1, E→M advance at the end of C33 if `hold`=0.
  - Total: 33 stall cycles.
- `hold` asserted during BUSY has no effect on iteration. `hold` asserted in DONE extends DONE cycle-for-cycle.
- Back-to-back divides: the second divide arrives in the cycle after DONE is left. It sees IDLE and starts at its own C0.
- Reset asserted mid-BUSY aborts immediately. No partial result is visible.

## Test plan
- DIVU a=100, b=7 → `div_stall` high for exactly 33 cycles from entry; then `lo`=14, `hi`=2, `result_valid`=1.
- DIV a=-7 (0xFFFFFFF9), b=2 → `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). Also DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU a=0x1234, b=0 → `lo`=0xFFFFFFFF, `hi`=0x1234, same 33-cycle stall.
- `hold`=1 for 5 cycles starting at C33 → state stays DONE, `div_stall`=0, `hi`/`lo` unchanged, no restart. Leaves DONE the cycle after `hold` falls.
- `flush` pulsed at C10 → `div_stall`=0 that cycle; IDLE at C11; `result_valid` never rises. A new divide at C12 completes normally with 33 stall cycles.
- Two back-to-back divides (200/10, then 9/4) → `lo`=20 then `lo`=2, `hi`=1, each with an independent 33-cycle stall. `rst` dropped at C20 of a third divide → all outputs 0 immediately.
